filter_channel_scheduler: RTL and testbench

- Time-multiplexes one FIR filter core among NumCh independent sample channels.
- Each channel presents samples over a four-phase req/ack input handshake and receives its filtered result over its own four-phase output handshake.
- The block arbitrates round-robin, forwards one sample at a time to the filter's four-phase input, and routes the filter's four-phase output back to the granted channel.
- Sits between the channel sources/sinks and a single `filter` instance; one sample is in flight at a time.

---
 rtl/filter_channel_scheduler.sv | 130 +++++++++++++
 tb/tb_filter_channel_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : filter_channel_scheduler
// Purpose  : Round-robin time-multiplexing of one FIR filter core among NumCh
//            four-phase sample channels, one sample in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module filter_channel_scheduler #(
  parameter int NumCh     = 4,
  parameter int DataWidth = 18,
  parameter int IdxWidth  = $clog2(NumCh > 1 ? NumCh : 2)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumCh*DataWidth-1:0] ch_data_i,
  input  logic [NumCh-1:0]           ch_req_i,
  output logic [NumCh-1:0]           ch_ack_o,
  output logic [DataWidth-1:0]       res_data_o,
  output logic [NumCh-1:0]           res_req_o,
  input  logic [NumCh-1:0]           res_ack_i,
  output logic [DataWidth-1:0]       flt_data_o,
  output logic                       flt_req_o,
  input  logic                       flt_ack_i,
  input  logic [DataWidth-1:0]       flt_data_i,
  input  logic                       flt_req_i,
  output logic                       flt_ack_o,
  output logic                       busy_o,
  output logic [IdxWidth-1:0]        grant_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_REL_IN   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_ACK_FLT  = 3'd4,
    S_DELIVER  = 3'd5,
    S_REL_OUT  = 3'd6
  } state_e;

  state_e               r_state;
  logic [IdxWidth-1:0]  r_rr;
  logic [IdxWidth-1:0]  r_grant;
  logic [DataWidth-1:0] r_smp;
  logic [DataWidth-1:0] r_res;

  logic                 w_found;
  logic [IdxWidth-1:0]  w_idx;
  logic [IdxWidth-1:0]  w_pick;
  logic [DataWidth-1:0] w_pick_data;
  logic [IdxWidth-1:0]  w_rr_next;
  logic [NumCh-1:0]     w_grant_oh;
  logic                 w_ch_req_g;
  logic                 w_res_ack_g;

  // First requester at or above the round-robin pointer, wrapping modulo NumCh.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_pick  = '0;
    for (int i = 0; i < NumCh; i++) begin
      w_idx = IdxWidth'((int'(r_rr) + i) % NumCh);
      if (!w_found && ch_req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_pick_data = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (w_pick == IdxWidth'(k)) w_pick_data = ch_data_i[k*DataWidth +: DataWidth];
    end
  end

  assign w_rr_next   = (r_grant == IdxWidth'(NumCh - 1)) ? '0 : r_grant + 1'b1;
  assign w_grant_oh  = NumCh'(1) << r_grant;
  assign w_ch_req_g  = ch_req_i[r_grant];
  assign w_res_ack_g = res_ack_i[r_grant];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_grant <= '0;
      r_smp   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_smp   <= w_pick_data;
            r_state <= S_FEED;
          end
        end
        S_FEED:     if (flt_ack_i) r_state <= S_REL_IN;
        S_REL_IN:   if (!flt_ack_i && !w_ch_req_g) r_state <= S_WAIT_RES;
        S_WAIT_RES: begin
          if (flt_req_i) begin
            r_res   <= flt_data_i;
            r_state <= S_ACK_FLT;
          end
        end
        S_ACK_FLT:  if (!flt_req_i) r_state <= S_DELIVER;
        S_DELIVER:  if (w_res_ack_g) r_state <= S_REL_OUT;
        S_REL_OUT: begin
          if (!w_res_ack_g) begin
            r_rr    <= w_rr_next;
            r_state <= S_IDLE;
          end
        end
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded purely from registered state.
  assign ch_ack_o   = (r_state == S_REL_IN)  ? w_grant_oh : '0;
  assign res_req_o  = (r_state == S_DELIVER) ? w_grant_oh : '0;
  assign flt_req_o  = (r_state == S_FEED);
  assign flt_ack_o  = (r_state == S_ACK_FLT);
  assign busy_o     = (r_state != S_IDLE);
  assign flt_data_o = r_smp;
  assign res_data_o = r_res;
  assign grant_o    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_filter_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_channel_scheduler
// Purpose  : Directed, table-driven bench acting as channel sources/sinks and
//            as a divide-by-four filter core around filter_channel_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`define WAIT_FOR(COND, NAME) \
  begin \
    int n_; \
    n_ = 0; \
    while (!(COND) && n_ < 2000) begin @(negedge clk_i); n_++; end \
    if (!(COND)) begin checks++; errors++; $display("FAIL %s: timed out waiting", NAME); end \
  end

module tb_filter_channel_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 18;
  localparam int IW  = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_req_i;
  logic [NCH-1:0]    ch_ack_o;
  logic [DW-1:0]     res_data_o;
  logic [NCH-1:0]    res_req_o;
  logic [NCH-1:0]    res_ack_i;
  logic [DW-1:0]     flt_data_o;
  logic              flt_req_o;
  logic              flt_ack_i;
  logic [DW-1:0]     flt_data_i;
  logic              flt_req_i;
  logic              flt_ack_o;
  logic              busy_o;
  logic [IW-1:0]     grant_o;

  logic [DW-1:0] ch_data_m [NCH];
  logic [DW-1:0] flt_got;
  logic [DW-1:0] last_res;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            rst;
    logic [3:0]    mask;
    int            exp_ch;
    logic [DW-1:0] smp;
    int            dly;
  } vec_t;
  vec_t vecs [13];

  filter_channel_scheduler #(.NumCh(NCH), .DataWidth(DW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ch_data_i  (ch_data_i),
    .ch_req_i   (ch_req_i),
    .ch_ack_o   (ch_ack_o),
    .res_data_o (res_data_o),
    .res_req_o  (res_req_o),
    .res_ack_i  (res_ack_i),
    .flt_data_o (flt_data_o),
    .flt_req_o  (flt_req_o),
    .flt_ack_i  (flt_ack_i),
    .flt_data_i (flt_data_i),
    .flt_req_i  (flt_req_i),
    .flt_ack_o  (flt_ack_o),
    .busy_o     (busy_o),
    .grant_o    (grant_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < NCH; k++) ch_data_i[k*DW +: DW] = ch_data_m[k];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_drives();
    ch_req_i   = '0;
    res_ack_i  = '0;
    flt_ack_i  = 1'b0;
    flt_req_i  = 1'b0;
    flt_data_i = '0;
    for (int k = 0; k < NCH; k++) ch_data_m[k] = '0;
    last_res = '0;
  endtask

  task automatic do_reset();
    clear_drives();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", {ch_ack_o, res_data_o, res_req_o, flt_data_o, flt_req_o,
                          flt_ack_o, busy_o, grant_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Source side: grant, sample to filter, input ack and its release.
  task automatic feed(input int ch, input bit imm, input bit spur);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    if (imm) begin
      @(negedge clk_i);
      chk("feed_latency", flt_req_o, 1);
    end else begin
      `WAIT_FOR(flt_req_o, "flt_req")
    end
    chk("grant", grant_o, ch);
    chk("flt_data", flt_data_o, ch_data_m[ch]);
    chk("busy_feed", busy_o, 1);
    if (spur) begin
      flt_data_i = 18'h3ffff;
      flt_req_i  = 1'b1;
      @(negedge clk_i);
      flt_req_i  = 1'b0;
      chk("spur_feed", {flt_req_o, ch_ack_o, res_req_o, res_data_o}, {1'b1, 4'b0, 4'b0, last_res});
    end
    flt_got   = flt_data_o;
    flt_ack_i = 1'b1;
    `WAIT_FOR(ch_ack_o != 0, "ch_ack")
    chk("ch_ack", {flt_req_o, ch_ack_o}, {1'b0, oh});
    if (spur) begin
      flt_req_i = 1'b1;
      @(negedge clk_i);
      flt_req_i = 1'b0;
      chk("spur_rel_in", {ch_ack_o, res_req_o, res_data_o}, {oh, 4'b0, last_res});
    end
    ch_req_i[ch] = 1'b0;
    flt_ack_i    = 1'b0;
    @(negedge clk_i);
    chk("ack_release", {ch_ack_o, flt_req_o, busy_o}, {4'b0, 1'b0, 1'b1});
  endtask

  // Filter core model: result is the sample divided by four.
  task automatic filt(input int dly);
    repeat (dly) @(negedge clk_i);
    flt_data_i = flt_got >> 2;
    flt_req_i  = 1'b1;
    `WAIT_FOR(flt_ack_o, "flt_ack")
    flt_req_i = 1'b0;
    `WAIT_FOR(!flt_ack_o, "flt_ack_release")
  endtask

  task automatic deliver(input int ch, input int hold);
    logic [3:0]    oh;
    logic [DW-1:0] exp;
    bit            ok;
    oh  = 4'b0001 << ch;
    exp = ch_data_m[ch] >> 2;
    `WAIT_FOR(res_req_o != 0, "res_req")
    chk("res_req", res_req_o, oh);
    chk("res_data", res_data_o, exp);
    last_res = exp;
    ok = 1'b1;
    repeat (hold) begin
      @(negedge clk_i);
      if (flt_req_o || !busy_o || ch_ack_o != 0 || res_req_o != oh) ok = 1'b0;
    end
    if (hold > 0) chk("stall_hold", ok, 1);
    res_ack_i[ch] = 1'b1;
    `WAIT_FOR(res_req_o == 0, "res_req_release")
    chk("res_data_rel_out", res_data_o, exp);
    res_ack_i[ch] = 1'b0;
    `WAIT_FOR(!busy_o, "idle")
    chk("grant_kept", grant_o, ch);
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_drives();
    flt_got = '0;

    vecs[0]  = '{1'b1, 4'b0100, 2, 18'd98,   130};
    vecs[1]  = '{1'b0, 4'b1010, 3, 18'd200,  3};
    vecs[2]  = '{1'b1, 4'b1111, 0, 18'd400,  5};
    vecs[3]  = '{1'b0, 4'b1111, 1, 18'd500,  2};
    vecs[4]  = '{1'b0, 4'b1111, 2, 18'd600,  2};
    vecs[5]  = '{1'b0, 4'b1111, 3, 18'd700,  2};
    vecs[6]  = '{1'b0, 4'b1111, 0, 18'd800,  2};
    vecs[7]  = '{1'b0, 4'b0000, 1, 18'd0,    2};
    vecs[8]  = '{1'b0, 4'b0000, 2, 18'd0,    2};
    vecs[9]  = '{1'b0, 4'b0000, 3, 18'd0,    2};
    vecs[10] = '{1'b0, 4'b0010, 1, 18'd900,  2};
    vecs[11] = '{1'b0, 4'b1010, 3, 18'd1000, 2};
    vecs[12] = '{1'b0, 4'b0000, 1, 18'd0,    2};

    // Pending channels keep their data; only newly raised requests load new samples.
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].rst) do_reset();
      for (int k = 0; k < NCH; k++) begin
        if (vecs[v].mask[k] && !ch_req_i[k]) begin
          ch_data_m[k] = vecs[v].smp + DW'(k);
          ch_req_i[k]  = 1'b1;
        end
      end
      feed(vecs[v].exp_ch, 1'b1, 1'b0);
      filt(vecs[v].dly);
      deliver(vecs[v].exp_ch, 0);
    end

    // Spurious filter results in FEED and REL_IN.
    do_reset();
    ch_data_m[0] = 18'd1234;
    ch_req_i[0]  = 1'b1;
    feed(0, 1'b1, 1'b1);
    filt(4);
    deliver(0, 0);

    // Asynchronous reset while waiting for the filter result.
    do_reset();
    ch_data_m[1] = 18'd777;
    ch_req_i[1]  = 1'b1;
    feed(1, 1'b1, 1'b0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", {ch_ack_o, res_data_o, res_req_o, flt_data_o, flt_req_o,
                           flt_ack_o, busy_o, grant_o}, 64'd0);
    clear_drives();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    ch_data_m[2] = 18'd300;
    ch_req_i[2]  = 1'b1;
    feed(2, 1'b1, 1'b0);
    filt(3);
    deliver(2, 0);

    // Slow sink on ch1 blocks a pending ch0.
    do_reset();
    ch_data_m[1] = 18'd600;
    ch_req_i[1]  = 1'b1;
    feed(1, 1'b1, 1'b0);
    filt(3);
    ch_data_m[0] = 18'd52;
    ch_req_i[0]  = 1'b1;
    deliver(1, 50);
    feed(0, 1'b1, 1'b0);
    filt(3);
    deliver(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`undef WAIT_FOR
`default_nettype wire
